// File: rtl/hash_op_requester.sv
// Request sequencer for the hashtable controller: buffers host ops,
// waits out the table lookup, commits for one cycle, returns a response.
module hash_op_requester #(
  parameter int KEY_WIDTH      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int LOOKUP_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [KEY_WIDTH-1:0]  req_key_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic [KEY_WIDTH-1:0]  rsp_key_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [2:0]            rsp_status_o,
  output logic [KEY_WIDTH-1:0]  ctrl_key_o,
  output logic [DATA_WIDTH-1:0] ctrl_data_o,
  output logic [1:0]            ctrl_op_o,
  input  logic [DATA_WIDTH-1:0] ctrl_read_data_i,
  input  logic                  ctrl_valid_i,
  input  logic                  ctrl_no_deletion_target_i,
  input  logic                  ctrl_no_write_space_i,
  input  logic                  ctrl_no_element_found_i,
  input  logic                  ctrl_key_already_present_i,
  output logic                  busy_o,
  output logic                  protocol_error_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(LOOKUP_LATENCY + 1);
  localparam int EW = 2 + KEY_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    COMMIT,
    RESPOND
  } state_t;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  init_q;
  logic                  full, empty, push, pop;
  logic [1:0]            head_op;
  logic [KEY_WIDTH-1:0]  head_key;
  logic [DATA_WIDTH-1:0] head_data;

  state_t                state_q, state_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [1:0]            op_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            rsp_op_q;
  logic [KEY_WIDTH-1:0]  rsp_key_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rdata_d;
  logic [2:0]            rsp_status_q, status_d;
  logic                  perr_q;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign req_ready_o = init_q & ~full;
  assign push  = req_valid_i & req_ready_o;
  assign pop   = (state_q == IDLE) & ~empty;
  assign {head_op, head_key, head_data} = mem_q[rd_ptr_q];

  // ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      init_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_op_i, req_key_i, req_data_i};
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (pop && head_op != 2'b00) begin
          state_d = LOOKUP;
          lat_d   = LW'(LOOKUP_LATENCY);
        end
      end
      LOOKUP: begin
        lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) state_d = COMMIT;
      end
      COMMIT:  state_d = RESPOND;
      RESPOND: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d = 3'd0;
    rdata_d  = '0;
    unique case (op_q)
      2'b01: begin
        if (ctrl_no_element_found_i) status_d = 3'd1;
        else rdata_d = ctrl_read_data_i;
      end
      2'b10: begin
        if (ctrl_key_already_present_i) status_d = 3'd3;
        else if (ctrl_no_write_space_i) status_d = 3'd2;
      end
      2'b11: if (ctrl_no_deletion_target_i) status_d = 3'd4;
      default: status_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      op_q         <= '0;
      key_q        <= '0;
      data_q       <= '0;
      rsp_op_q     <= '0;
      rsp_key_q    <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (pop) {op_q, key_q, data_q} <= {head_op, head_key, head_data};
      if (state_q == COMMIT) begin
        rsp_op_q     <= op_q;
        rsp_key_q    <= key_q;
        rsp_data_q   <= rdata_d;
        rsp_status_q <= status_d;
        if (!ctrl_valid_i) perr_q <= 1'b1;
      end
    end
  end

  // op is gated by state so reset drops it without waiting for an edge
  assign ctrl_op_o        = (state_q == COMMIT) ? op_q : 2'b00;
  assign ctrl_key_o       = key_q;
  assign ctrl_data_o      = data_q;
  assign rsp_valid_o      = (state_q == RESPOND);
  assign rsp_op_o         = rsp_op_q;
  assign rsp_key_o        = rsp_key_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_status_o     = rsp_status_q;
  assign busy_o           = (state_q != IDLE) | ~empty;
  assign protocol_error_o = perr_q;

endmodule

// File: tb/tb_hash_op_requester.sv
// Bench for hash_op_requester: table vectors, scoreboard of responses,
// controller flag model fed in commit order.
module tb_hash_op_requester;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic [31:0] rd;
    logic        nf;
    logic        nws;
    logic        kap;
    logic        ndt;
    logic [2:0]  st;
    logic [31:0] edata;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic [31:0] rd;
    logic        nf;
    logic        nws;
    logic        kap;
    logic        ndt;
    logic        vld;
  } flag_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic [2:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [1:0]  req_key_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_op_o;
  logic [1:0]  rsp_key_o;
  logic [31:0] rsp_data_o;
  logic [2:0]  rsp_status_o;
  logic [1:0]  ctrl_key_o;
  logic [31:0] ctrl_data_o;
  logic [1:0]  ctrl_op_o;
  logic [31:0] ctrl_read_data_i;
  logic        ctrl_valid_i;
  logic        ctrl_no_deletion_target_i;
  logic        ctrl_no_write_space_i;
  logic        ctrl_no_element_found_i;
  logic        ctrl_key_already_present_i;
  logic        busy_o;
  logic        protocol_error_o;

  hash_op_requester #(
    .KEY_WIDTH(2), .DATA_WIDTH(32),
    .FIFO_DEPTH(4), .LOOKUP_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i),
    .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_op_o(rsp_op_o), .rsp_key_o(rsp_key_o),
    .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .ctrl_key_o(ctrl_key_o), .ctrl_data_o(ctrl_data_o),
    .ctrl_op_o(ctrl_op_o),
    .ctrl_read_data_i(ctrl_read_data_i),
    .ctrl_valid_i(ctrl_valid_i),
    .ctrl_no_deletion_target_i(ctrl_no_deletion_target_i),
    .ctrl_no_write_space_i(ctrl_no_write_space_i),
    .ctrl_no_element_found_i(ctrl_no_element_found_i),
    .ctrl_key_already_present_i(ctrl_key_already_present_i),
    .busy_o(busy_o), .protocol_error_o(protocol_error_o)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    commits = 0;
  int    rsp_count = 0;
  logic  pend = 1'b0;
  flag_t flags_q[$];
  exp_t  sb[$];
  vec_t  tbl[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ctrl();
    flag_t f;
    if (flags_q.size() > 0) begin
      f = flags_q[0];
      ctrl_read_data_i           = f.rd;
      ctrl_valid_i               = f.vld;
      ctrl_no_element_found_i    = f.nf;
      ctrl_no_write_space_i      = f.nws;
      ctrl_key_already_present_i = f.kap;
      ctrl_no_deletion_target_i  = f.ndt;
    end else begin
      ctrl_read_data_i           = 32'h0;
      ctrl_valid_i               = 1'b1;
      ctrl_no_element_found_i    = 1'b0;
      ctrl_no_write_space_i      = 1'b0;
      ctrl_key_already_present_i = 1'b0;
      ctrl_no_deletion_target_i  = 1'b0;
    end
  endtask

  task automatic mon_step();
    flag_t f;
    exp_t  e;
    logic [31:0] wd;
    if (!rst_n) begin
      flags_q.delete();
      sb.delete();
      pend = 1'b0;
      drive_ctrl();
      return;
    end
    if (pend) begin
      f = flags_q.pop_front();
      pend = 1'b0;
    end
    if (ctrl_op_o != 2'b00) begin
      commits++;
      if (flags_q.size() == 0) begin
        chk("commit_unexpected", {62'h0, ctrl_op_o}, 64'h0);
      end else begin
        f = flags_q[0];
        wd = (f.op == 2'b10) ? ctrl_data_o : 32'h0;
        chk("commit", {ctrl_op_o, ctrl_key_o, wd},
            {f.op, f.key, (f.op == 2'b10) ? f.data : 32'h0});
        pend = 1'b1;
      end
    end
    drive_ctrl();
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_count++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {63'h0, rsp_valid_o}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp", {rsp_op_o, rsp_key_o, rsp_data_o, rsp_status_o},
            {e.op, e.key, e.data, e.st});
      end
    end
  endtask

  task automatic send(input vec_t v, input logic vld);
    flag_t f;
    exp_t  e;
    int    n;
    if (v.op != 2'b00) begin
      f = '{v.op, v.key, v.data, v.rd, v.nf, v.nws, v.kap, v.ndt, vld};
      e = '{v.op, v.key, v.edata, v.st};
      flags_q.push_back(f);
      sb.push_back(e);
    end
    req_valid_i = 1'b1;
    req_op_i    = v.op;
    req_key_i   = v.key;
    req_data_i  = v.data;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", {63'h0, req_ready_o}, 64'h1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", {62'h0, busy_o, sb.size() != 0}, 64'h0);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] key,
                              input logic [31:0] data, input logic [31:0] rd,
                              input logic [3:0] fl, input logic [2:0] st,
                              input logic [31:0] ed);
    vec_t v;
    v.op = op; v.key = key; v.data = data; v.rd = rd;
    {v.nf, v.nws, v.kap, v.ndt} = fl;
    v.st = st; v.edata = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   c0, r0, lat;
    // flags nibble order: {no_found, no_space, key_present, no_del}
    tbl[0] = mk(2'b01, 2'd1, 32'h0, 32'h12345678, 4'b0000, 3'd0, 32'h12345678);
    tbl[1] = mk(2'b01, 2'd2, 32'h0, 32'hAAAA5555, 4'b1000, 3'd1, 32'h0);
    tbl[2] = mk(2'b10, 2'd3, 32'h1, 32'h0, 4'b0110, 3'd3, 32'h0);
    tbl[3] = mk(2'b10, 2'd0, 32'h2, 32'h0, 4'b0100, 3'd2, 32'h0);
    tbl[4] = mk(2'b11, 2'd1, 32'h0, 32'h0, 4'b0001, 3'd4, 32'h0);
    tbl[5] = mk(2'b11, 2'd2, 32'h0, 32'h0, 4'b0000, 3'd0, 32'h0);
    tbl[6] = mk(2'b01, 2'd3, 32'h0, 32'hCAFEF00D, 4'b0011, 3'd0, 32'hCAFEF00D);
    tbl[7] = mk(2'b10, 2'd2, 32'h77, 32'h0, 4'b1000, 3'd0, 32'h0);

    rst_n = 1'b0;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    req_key_i = 2'd0; req_data_i = 32'h0;
    rsp_ready_i = 1'b1;
    drive_ctrl();
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    #1;
    chk("rst_outs", {req_ready_o, rsp_valid_o, busy_o, protocol_error_o,
                     ctrl_op_o, ctrl_key_o, rsp_status_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", {63'h0, req_ready_o}, 64'h0);
    @(posedge clk); #1;
    chk("ready_post_edge", {63'h0, req_ready_o}, 64'h1);

    c0 = commits;
    v = mk(2'b10, 2'd1, 32'hDEADBEEF, 32'h0, 4'b0000, 3'd0, 32'h0);
    send(v, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rsp_valid_o) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd4);
    wait_drain();
    chk("commit_once", 64'(commits - c0), 64'd1);

    for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
    wait_drain();

    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk(2'b10, 2'(i), 32'h100 + 32'(i), 32'h0, 4'b0000, 3'd0, 32'h0);
      send(v, 1'b1);
    end
    chk("full_ready", {62'h0, req_ready_o, busy_o}, 64'h1);
    r0 = rsp_count;
    fork
      begin
        v = mk(2'b10, 2'd1, 32'h105, 32'h0, 4'b0000, 3'd0, 32'h0);
        send(v, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("full_hold", {62'h0, req_ready_o, rsp_valid_o}, 64'h1);
        rsp_ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("burst_count", 64'(rsp_count - r0), 64'd6);

    r0 = rsp_count;
    c0 = commits;
    send(mk(2'b01, 2'd1, 32'h0, 32'h0BADF00D, 4'b0000, 3'd0, 32'h0BADF00D), 1'b1);
    send(mk(2'b00, 2'd2, 32'h0, 32'h0, 4'b0000, 3'd0, 32'h0), 1'b1);
    send(mk(2'b01, 2'd2, 32'h0, 32'h00000077, 4'b0000, 3'd0, 32'h77), 1'b1);
    wait_drain();
    chk("nop_rsps", 64'(rsp_count - r0), 64'd2);
    chk("nop_commits", 64'(commits - c0), 64'd2);

    chk("perr_before", {63'h0, protocol_error_o}, 64'h0);
    send(mk(2'b01, 2'd0, 32'h0, 32'h11, 4'b0000, 3'd0, 32'h11), 1'b0);
    wait_drain();
    chk("perr_set", {63'h0, protocol_error_o}, 64'h1);
    send(mk(2'b10, 2'd3, 32'h9, 32'h0, 4'b0000, 3'd0, 32'h0), 1'b1);
    wait_drain();
    chk("perr_sticky", {63'h0, protocol_error_o}, 64'h1);

    send(mk(2'b10, 2'd2, 32'h55AA, 32'h0, 4'b0000, 3'd0, 32'h0), 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (ctrl_op_o == 2'b10) break;
      @(posedge clk); #1;
    end
    chk("commit_seen", {62'h0, ctrl_op_o}, 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {ctrl_op_o, rsp_valid_o, busy_o, req_ready_o,
                    protocol_error_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'h0, req_ready_o}, 64'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_empty", {61'h0, busy_o, rsp_valid_o, protocol_error_o},
        64'h0);

    send(mk(2'b01, 2'd3, 32'h0, 32'h5A5A5A5A, 4'b0000, 3'd0, 32'h5A5A5A5A),
         1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_op_requester.md
Name: hash_op_requester

Overview:
- Front-end sequencer for the hashtable controller. It accepts host requests (read, write, delete) over a valid/ready handshake and buffers them in a small FIFO.
- It presents each request's key and data to the hash units and table memories, and waits the fixed memory lookup latency. It then issues the op code to the controller for exactly one commit cycle.
- It converts the controller's result flags into one response per request, returned over valid/ready.

Parameters:
- KEY_WIDTH, 2, key width; must match the controller.
- DATA_WIDTH, 32, data width; must match the controller.
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- LOOKUP_LATENCY, 2, cycles from a stable key on ctrl_key_o to valid table read-out at the controller inputs; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  request FIFO not full.
- req_op_i  in  2  00 nop, 01 read, 10 write, 11 delete.
- req_key_i  in  KEY_WIDTH  request key.
- req_data_i  in  DATA_WIDTH  write data; ignored for read and delete.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host accepts response.
- rsp_op_o  out  2  op code of the completed request.
- rsp_key_o  out  KEY_WIDTH  key of the completed request.
- rsp_data_o  out  DATA_WIDTH  read data; zero for write and delete.
- rsp_status_o  out  3  0 ok, 1 not found, 2 no write space, 3 key already present, 4 no deletion target.
- ctrl_key_o  out  KEY_WIDTH  key to hash units and controller.
- ctrl_data_o  out  DATA_WIDTH  data to controller.
- ctrl_op_o  out  2  controller op code.
- ctrl_read_data_i  in  DATA_WIDTH  controller read data.
- ctrl_valid_i  in  1  controller valid.
- ctrl_no_deletion_target_i  in  1  controller flag.
- ctrl_no_write_space_i  in  1  controller flag.
- ctrl_no_element_found_i  in  1  controller flag.
- ctrl_key_already_present_i  in  1  controller flag.
- busy_o  out  1  FSM not in IDLE, or FIFO not empty.
- protocol_error_o  out  1  sticky error flag.

Behaviour:
Reset:
- While rst_n is low: FIFO empty, FSM in IDLE, all outputs 0, and req_ready_o = 0.
- req_ready_o rises on the first clock edge after rst_n deasserts.
- Reset asserted mid-operation aborts it immediately. ctrl_op_o goes to 00 asynchronously, so no partial write is ever committed.

Request FIFO:
- A push occurs on req_valid_i & req_ready_o. req_ready_o = !full.
- A push and a pop in the same cycle are both honoured.
- Pointers wrap modulo FIFO_DEPTH. A full/empty counter tracks occupancy.

FSM states: IDLE, LOOKUP, COMMIT, RESPOND.
- IDLE:
  - ctrl_op_o = 00.
  - If the FIFO is not empty, pop the head into working registers (op, key, data).
  - If the popped op is 00, discard it, stay in IDLE, and produce no response.
  - Otherwise load cnt = LOOKUP_LATENCY and go to LOOKUP.
- LOOKUP:
  - ctrl_key_o and ctrl_data_o come from the working registers and are held stable. ctrl_op_o = 00.
  - Decrement cnt each cycle. When cnt == 1, go to COMMIT.
- COMMIT (exactly 1 cycle):
  - ctrl_op_o = working op.
  - On the clock edge, capture rsp_op, rsp_key, rsp_data and rsp_status, then go to RESPOND.
  - If ctrl_valid_i = 0 during COMMIT, set protocol_error_o. It stays set until reset.
- RESPOND:
  - rsp_valid_o = 1. ctrl_op_o = 00.
  - Response outputs hold stable until rsp_valid_o & rsp_ready_i, then go to IDLE.
  - Backpressure is unbounded. The FIFO keeps accepting requests while in RESPOND.

Status mapping, sampled in COMMIT:
- Read: no_element_found gives 1. Otherwise 0, with rsp_data_o = ctrl_read_data_i.
- Write: key_already_present gives 3. Otherwise no_write_space gives 2. Otherwise 0. Key-present has priority.
- Delete: no_deletion_target gives 4. Otherwise 0.

Timing:
- Latency, FIFO empty and FSM idle: request accepted at edge E0, rsp_valid_o high after edge E0 + LOOKUP_LATENCY + 2.
- Throughput: one operation per LOOKUP_LATENCY + 3 cycles with rsp_ready_i held at 1.
- Ordering: responses are returned strictly in request order.

Test Plan:
- Reset, then write key=1, data=0xDEADBEEF with controller flags all 0 -> exactly one COMMIT cycle with ctrl_op_o = 10; rsp_status = 0 and rsp_valid_o high 4 edges after accept (LOOKUP_LATENCY = 2).
- Read key=1 with ctrl_read_data_i = 0x12345678 -> rsp_data_o = 0x12345678, rsp_status = 0. Read with no_element_found = 1 -> status 1, data 0.
- Write with key_already_present = 1 and no_write_space = 1 together -> status 3. Delete with no_deletion_target = 1 -> status 4.
- Push 6 requests back-to-back with rsp_ready_i = 0 (FIFO_DEPTH = 4) -> req_ready_o drops once the FIFO is full; after releasing rsp_ready_i, all requests complete in order with correct keys and no loss.
- Nop request between two reads -> exactly 2 responses; ctrl_op_o never 00→nonzero outside COMMIT.
- Assert rst_n low during COMMIT -> ctrl_op_o goes to 00 at once, rsp_valid_o = 0, FIFO empty. Separately, hold ctrl_valid_i = 0 during COMMIT -> protocol_error_o = 1 and stays set until reset.
